// File: rtl/spec_avg_if.sv
// rtl/spec_avg_if.sv - Avalon-ST sink and source signal bundle for the spectrum averager
interface spec_avg_if;
    logic [31:0] snk_data;
    logic        snk_valid;
    logic        snk_sop;
    logic        snk_eop;
    logic        snk_ready;
    logic [31:0] src_data;
    logic        src_valid;
    logic        src_sop;
    logic        src_eop;
    logic [1:0]  src_empty;
    logic        src_ready;

    modport master (
        output snk_data, snk_valid, snk_sop, snk_eop,
        input  snk_ready,
        input  src_data, src_valid, src_sop, src_eop, src_empty,
        output src_ready
    );

    modport slave (
        input  snk_data, snk_valid, snk_sop, snk_eop,
        output snk_ready,
        output src_data, src_valid, src_sop, src_eop, src_empty,
        input  src_ready
    );
endinterface

// File: rtl/spec_avg.sv
// rtl/spec_avg.sv - accumulates 2^NAVG_LOG2 frames bin-by-bin in RAM, then streams the truncated mean
module spec_avg #(
    parameter int FRAME_LEN = 8192,
    parameter int NAVG_LOG2 = 2,
    parameter int AW        = 13
) (
    input  logic      nios_clk,
    input  logic      reset,
    input  logic      clear,
    spec_avg_if.slave st,
    output logic      frame_err,
    output logic      busy
);
    localparam int DW = 32 + NAVG_LOG2;
    localparam logic [AW-1:0] LAST_BIN = AW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {WAIT_SOP, ACCUM, DUMP} state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        bin_cnt_q, bin_cnt_d;
    logic [NAVG_LOG2-1:0] frm_cnt_q, frm_cnt_d;
    logic                 frame_err_q, frame_err_d;
    logic                 snk_ready_q, snk_ready_d;
    logic                 busy_q, busy_d;

    logic                 wr_pend_q, wr_pend_d;
    logic [AW-1:0]        wr_addr_q, wr_addr_d;
    logic [31:0]          wr_data_q, wr_data_d;
    logic                 wr_first_q, wr_first_d;

    logic [AW:0]          rd_cnt_q, rd_cnt_d;
    logic                 rd_vld_q, rd_vld_d;
    logic [AW-1:0]        rd_idx_q, rd_idx_d;

    logic                 out_v_q, out_v_d;
    logic [31:0]          out_data_q, out_data_d;
    logic                 out_sop_q, out_sop_d;
    logic                 out_eop_q, out_eop_d;
    logic                 skid_v_q, skid_v_d;
    logic [31:0]          skid_data_q, skid_data_d;
    logic                 skid_sop_q, skid_sop_d;
    logic                 skid_eop_q, skid_eop_d;

    logic [DW-1:0]        mem [FRAME_LEN];
    logic [DW-1:0]        rdata_q;
    logic [AW-1:0]        rd_addr;
    logic [DW-1:0]        wr_word;
    logic                 beat;
    logic                 pop;
    logic                 issue;
    logic [1:0]           fill;

    // The sum read back one cycle after the beat completes the read-modify-write.
    assign wr_word = wr_first_q ? DW'(wr_data_q) : rdata_q + DW'(wr_data_q);

    always_ff @(posedge nios_clk) begin
        if (wr_pend_q) begin
            mem[wr_addr_q] <= wr_word;
        end
        rdata_q <= mem[rd_addr];
    end

    always_comb begin
        state_d     = state_q;
        bin_cnt_d   = bin_cnt_q;
        frm_cnt_d   = frm_cnt_q;
        frame_err_d = frame_err_q;
        wr_pend_d   = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_first_d  = wr_first_q;
        rd_cnt_d    = rd_cnt_q;
        rd_vld_d    = 1'b0;
        rd_idx_d    = rd_idx_q;
        out_v_d     = out_v_q;
        out_data_d  = out_data_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        skid_v_d    = skid_v_q;
        skid_data_d = skid_data_q;
        skid_sop_d  = skid_sop_q;
        skid_eop_d  = skid_eop_q;
        rd_addr     = bin_cnt_q;
        beat        = st.snk_valid && snk_ready_q;
        pop         = out_v_q && st.src_ready;
        fill        = 2'(out_v_q) + 2'(skid_v_q) + 2'(rd_vld_q);
        issue       = 1'b0;

        case (state_q)
            WAIT_SOP, ACCUM: begin
                rd_cnt_d = '0;
                if (beat && (state_q == ACCUM || st.snk_sop)) begin
                    wr_pend_d  = 1'b1;
                    wr_addr_d  = bin_cnt_q;
                    wr_data_d  = st.snk_data;
                    wr_first_d = (frm_cnt_q == '0);
                    if (st.snk_sop && bin_cnt_q != '0) begin
                        frame_err_d = 1'b1;
                        frm_cnt_d   = '0;
                        wr_addr_d   = '0;
                        wr_first_d  = 1'b1;
                        rd_addr     = '0;
                        bin_cnt_d   = AW'(1);
                        state_d     = ACCUM;
                    end else if (st.snk_eop != (bin_cnt_q == LAST_BIN)) begin
                        frame_err_d = 1'b1;
                        frm_cnt_d   = '0;
                        bin_cnt_d   = '0;
                        state_d     = WAIT_SOP;
                    end else if (st.snk_eop) begin
                        bin_cnt_d = '0;
                        frm_cnt_d = frm_cnt_q + 1'b1;
                        state_d   = (&frm_cnt_q) ? DUMP : WAIT_SOP;
                    end else begin
                        bin_cnt_d = bin_cnt_q + 1'b1;
                        state_d   = ACCUM;
                    end
                end
            end
            DUMP: begin
                // Issue only when the two-entry output buffer is guaranteed room on arrival.
                issue    = !rd_cnt_q[AW] && (fill != 2'd2 || pop);
                rd_addr  = rd_cnt_q[AW-1:0];
                rd_vld_d = issue;
                rd_idx_d = rd_cnt_q[AW-1:0];
                rd_cnt_d = rd_cnt_q + (AW+1)'(issue);
                if (pop) begin
                    out_v_d    = skid_v_q;
                    out_data_d = skid_data_q;
                    out_sop_d  = skid_sop_q;
                    out_eop_d  = skid_eop_q;
                    skid_v_d   = 1'b0;
                    if (out_eop_q) begin
                        state_d = WAIT_SOP;
                    end
                end
                if (rd_vld_q) begin
                    if (!out_v_d) begin
                        out_v_d    = 1'b1;
                        out_data_d = rdata_q[DW-1:NAVG_LOG2];
                        out_sop_d  = (rd_idx_q == '0);
                        out_eop_d  = (rd_idx_q == LAST_BIN);
                    end else begin
                        skid_v_d    = 1'b1;
                        skid_data_d = rdata_q[DW-1:NAVG_LOG2];
                        skid_sop_d  = (rd_idx_q == '0);
                        skid_eop_d  = (rd_idx_q == LAST_BIN);
                    end
                end
            end
            default: state_d = WAIT_SOP;
        endcase

        if (clear) begin
            state_d     = WAIT_SOP;
            bin_cnt_d   = '0;
            frm_cnt_d   = '0;
            frame_err_d = 1'b0;
            wr_pend_d   = 1'b0;
            rd_cnt_d    = '0;
            rd_vld_d    = 1'b0;
            out_v_d     = 1'b0;
            skid_v_d    = 1'b0;
        end

        snk_ready_d = (state_d != DUMP);
        busy_d      = (state_d == DUMP);
    end

    always_ff @(posedge nios_clk or posedge reset) begin
        if (reset) begin
            state_q     <= WAIT_SOP;
            bin_cnt_q   <= '0;
            frm_cnt_q   <= '0;
            frame_err_q <= 1'b0;
            snk_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            wr_pend_q   <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_first_q  <= 1'b0;
            rd_cnt_q    <= '0;
            rd_vld_q    <= 1'b0;
            rd_idx_q    <= '0;
            out_v_q     <= 1'b0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            skid_v_q    <= 1'b0;
            skid_data_q <= '0;
            skid_sop_q  <= 1'b0;
            skid_eop_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_cnt_q   <= bin_cnt_d;
            frm_cnt_q   <= frm_cnt_d;
            frame_err_q <= frame_err_d;
            snk_ready_q <= snk_ready_d;
            busy_q      <= busy_d;
            wr_pend_q   <= wr_pend_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_first_q  <= wr_first_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_vld_q    <= rd_vld_d;
            rd_idx_q    <= rd_idx_d;
            out_v_q     <= out_v_d;
            out_data_q  <= out_data_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            skid_v_q    <= skid_v_d;
            skid_data_q <= skid_data_d;
            skid_sop_q  <= skid_sop_d;
            skid_eop_q  <= skid_eop_d;
        end
    end

    assign st.snk_ready = snk_ready_q;
    assign st.src_data  = out_data_q;
    assign st.src_valid = out_v_q;
    assign st.src_sop   = out_sop_q;
    assign st.src_eop   = out_eop_q;
    assign st.src_empty = 2'b00;
    assign frame_err    = frame_err_q;
    assign busy         = busy_q;
endmodule

// File: doc/spec_avg.md
Name: spec_avg

Overview:
- Spectrum averager on the nios_clk side, directly downstream of the log-power Avalon-ST output (32-bit bins, sop/eop framed, empty).
- Accumulates 2^NAVG_LOG2 consecutive frames bin-by-bin in on-chip RAM.
- Then streams one averaged frame out over an Avalon-ST source towards the NIOS DMA, reducing the host data rate and noise.

Parameters:
- FRAME_LEN, 8192, bins per frame; power of two.
- NAVG_LOG2, 2, log2 of the number of frames averaged (1..8).
- AW, 13, bin address width = log2(FRAME_LEN).

Ports:
- nios_clk  in  1  single clock.
- reset  in  1  asynchronous, active-high.
- clear  in  1  synchronous; discards the partial average and returns to WAIT_SOP.
- snk_data  in  32  input bin, unsigned.
- snk_valid  in  1  sink beat valid.
- snk_sop  in  1  sink start of frame.
- snk_eop  in  1  sink end of frame.
- snk_ready  out  1  sink ready.
- src_data  out  32  averaged bin.
- src_valid  out  1  source beat valid.
- src_sop  out  1  source start of frame.
- src_eop  out  1  source end of frame.
- src_empty  out  2  source empty; constant 2'b00.
- src_ready  in  1  source ready.
- frame_err  out  1  sticky framing error; cleared by reset or clear.
- busy  out  1  high in DUMP.

Behaviour:
- Reset values: snk_ready=0, src_valid=0, src_sop=0, src_eop=0, src_data=0, frame_err=0, busy=0. State after reset is WAIT_SOP. bin_cnt=0, frm_cnt=0.
- Beat definition: a sink beat is snk_valid&&snk_ready. A source beat is src_valid&&src_ready.
- RAM: FRAME_LEN x (32+NAVG_LOG2), single clock, 1-cycle read latency. Sums cannot overflow; no saturation logic.

States:
- WAIT_SOP: snk_ready=1. Beats without sop are dropped. A beat with sop is processed as bin 0 of the frame and moves the state to ACCUM.
- ACCUM: snk_ready=1; one beat per cycle is sustained.
  - Frame 0 (frm_cnt==0): RAM[bin]=zero-extended snk_data, overwriting the previous contents.
  - Later frames: RAM[bin]=RAM[bin]+snk_data, read-modify-write pipelined.
  - Back-to-back beats use different addresses, so there is no hazard.
  - bin_cnt increments on every beat.
- Frame end: a beat with eop at bin_cnt==FRAME_LEN-1 completes the frame.
  - frm_cnt increments.
  - If frm_cnt reaches 2^NAVG_LOG2, frm_cnt clears and the state moves to DUMP.
  - Otherwise the state moves to WAIT_SOP.
- Framing errors:
  - eop at bin_cnt!=FRAME_LEN-1.
  - bin_cnt==FRAME_LEN-1 without eop.
  - sop at bin_cnt!=0 inside ACCUM.
  - Response to any of these: frame_err<=1, frm_cnt<=0, bin_cnt<=0, discard the frame.
  - A sop-triggered error re-enters ACCUM with that beat as bin 0. The other two errors go to WAIT_SOP.
- DUMP: snk_ready=0, busy=1.
  - Reads RAM 0..FRAME_LEN-1 in order.
  - src_data=RAM[i][NAVG_LOG2+31:NAVG_LOG2], i.e. truncating divide.
  - src_sop on i=0; src_eop on i=FRAME_LEN-1.
  - First src_valid appears within 2 cycles of entering DUMP.
  - With src_ready held high, one beat per cycle with no bubbles; use a prefetch/skid stage over the RAM latency.
  - While src_valid&&!src_ready, src_data, src_sop and src_eop hold stable.
  - After the eop beat, the state moves to WAIT_SOP with busy=0 in the next cycle.
- clear: behaves like reset for the state, counters and frame_err, but is synchronous.
  - Mid-DUMP, it drops src_valid the next cycle, even without eop.
  - RAM contents are not cleared; frame 0 overwrites them.
- Simultaneous clear and beat: clear wins and the beat is dropped.

Test Plan (FRAME_LEN=8, NAVG_LOG2=2):
- 4 well-formed frames, bin k of frame f = 100*f+k, src_ready=1 -> one output frame, 8 beats back-to-back. src_data[k]=(600+4k)>>2=150+k, sop on beat 0, eop on beat 7. frame_err=0.
- Same stimulus but with beats from a second average arriving during DUMP -> snk_ready=0 throughout DUMP. Accumulation resumes only on the next sop after busy falls.
- src_ready toggled pseudo-randomly during DUMP -> exactly 8 source beats, values 150..157 in order, data stable while stalled.
- Frame 2 carries eop at bin 5 -> frame_err=1 and no output. The next 4 good frames (values 0xFFFFFFFF) output 0xFFFFFFFF per bin, confirming there is no overflow.
- Beats without sop in WAIT_SOP, then a sop -> the pre-sop beats are ignored and the averages match frames starting at sop.
- clear asserted mid-ACCUM and mid-DUMP -> src_valid=0 the next cycle and frame_err=0. The next 4 frames average correctly, unaffected by stale RAM.
